// File: rtl/esp32_prog_sequencer_pkg.sv
// esp32_prog_pkg: state encoding, DTR/RTS decode constants and defaults
// for the ESP32 reset/bootstrap sequencer.
package esp32_prog_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    RESET   = 2'd1,
    BOOT    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [1:0] P_RESET = 2'b10;
  localparam logic [1:0] P_BOOT  = 2'b01;

  localparam int C_FILTER_CYCLES_DEF = 16;
  localparam int C_RELEASE_BITS_DEF  = 17;

endpackage

// File: rtl/esp32_prog_sequencer_if.sv
// esp32_prog_sequencer_if: FTDI/button inputs and ESP32 control outputs.
// master = passthru top level, slave = sequencer.
interface esp32_prog_sequencer_if;
  logic       ftdi_ndtr;
  logic       ftdi_nrts;
  logic       btn_n;
  logic       wifi_en;
  logic       wifi_gpio0;
  logic       strap_oe;
  logic       prog_active;
  logic [1:0] state_o;

  modport master (
    output ftdi_ndtr, ftdi_nrts, btn_n,
    input  wifi_en, wifi_gpio0, strap_oe,
    input  prog_active, state_o
  );

  modport slave (
    input  ftdi_ndtr, ftdi_nrts, btn_n,
    output wifi_en, wifi_gpio0, strap_oe,
    output prog_active, state_o
  );
endinterface

// File: rtl/esp32_prog_sequencer_sync_filter.sv
// sync_filter: 2-flop synchroniser plus stability filter; p only takes
// a value that stayed unchanged for C_filter_cycles after sync.
module sync_filter
  import esp32_prog_pkg::*;
#(
  parameter int W               = 2,
  parameter int C_filter_cycles = C_FILTER_CYCLES_DEF
) (
  input  logic         clk_25mhz,
  input  logic         reset,
  input  logic [W-1:0] raw,
  output logic [W-1:0] p
);
  localparam logic [7:0] C_MAX = 8'(C_filter_cycles);

  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic [W-1:0] cand;
  logic [7:0]   cnt;

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      s1   <= '1;
      s2   <= '1;
      cand <= '1;
      cnt  <= '0;
      p    <= '1;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        cnt  <= '0;
      end else if (cnt != C_MAX) begin
        cnt <= cnt + 8'd1;
        if (cnt == C_MAX - 8'd1)
          p <= cand;
      end
    end
  end
endmodule

// File: rtl/esp32_prog_sequencer.sv
// esp32_prog_sequencer: filtered DTR/RTS -> timed ESP32 EN/IO0/strap drive.
// Define ESP32_PROG_BTN_EN to let btn_n force IO0 low.
module esp32_prog_sequencer
  import esp32_prog_pkg::*;
#(
  parameter int C_filter_cycles = C_FILTER_CYCLES_DEF,
  parameter int C_release_bits  = C_RELEASE_BITS_DEF
) (
  input logic                   clk_25mhz,
  input logic                   reset,
  esp32_prog_sequencer_if.slave bus
);
  localparam int RW = C_release_bits + 1;
  localparam logic [RW-1:0] ONE = RW'(1);

  logic [1:0]    p;
  logic          btn_ok;
  state_t        state;
  state_t        next;
  logic [RW-1:0] rel_cnt;
  logic          rel_done;
  logic          strap_q;
  logic          strap_d;
  logic          act_q;
  logic          en_q;
  logic          io0_q;

  sync_filter #(
    .W              (2),
    .C_filter_cycles(C_filter_cycles)
  ) u_filter (
    .clk_25mhz(clk_25mhz),
    .reset    (reset),
    .raw      ({bus.ftdi_ndtr, bus.ftdi_nrts}),
    .p        (p)
  );

`ifdef ESP32_PROG_BTN_EN
  logic [1:0] btn_sync;

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) btn_sync <= 2'b11;
    else       btn_sync <= {btn_sync[0], bus.btn_n};
  end

  assign btn_ok = btn_sync[1];
`else
  logic btn_unused;

  assign btn_unused = bus.btn_n;
  assign btn_ok     = 1'b1;
`endif

  assign rel_done = rel_cnt[RW-1];

  always_comb begin
    next = state;
    unique case (state)
      RUN: begin
        if (p == P_RESET) next = RESET;
      end
      RESET: begin
        if (p == P_BOOT)       next = BOOT;
        else if (p != P_RESET) next = RUN;
      end
      BOOT: begin
        if (p == P_RESET)     next = RESET;
        else if (p != P_BOOT) next = RELEASE;
      end
      RELEASE: begin
        if (p == P_RESET) next = RESET;
        else if (rel_done) next = RUN;
      end
      default: next = RUN;
    endcase
    // an abort back to RESET keeps the straps driven
    strap_d = (next == BOOT) || (next == RELEASE)
           || (next == RESET && strap_q);
  end

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      rel_cnt <= '0;
      strap_q <= 1'b0;
      act_q   <= 1'b0;
      en_q    <= 1'b1;
      io0_q   <= 1'b1;
    end else begin
      state   <= next;
      strap_q <= strap_d;
      act_q   <= (next == BOOT) || (next == RELEASE);
      if (next == RESET || next == BOOT)
        rel_cnt <= '0;
      else if (state == RELEASE && next == RELEASE && !rel_done)
        rel_cnt <= rel_cnt + ONE;
      en_q  <= (p != P_RESET);
      io0_q <= (p != P_BOOT) && btn_ok;
    end
  end

  assign bus.wifi_en     = en_q;
  assign bus.wifi_gpio0  = io0_q;
  assign bus.strap_oe    = strap_q;
  assign bus.prog_active = act_q;
  assign bus.state_o     = state;
endmodule
